// File: rtl/riscv_core_adder_arbiter.sv
// riscv_core_adder_arbiter: round-robin arbiter sharing one XLEN-bit add/sub
// datapath among NREQ requesters. It has one registered, ID-tagged response slot.
// Optional feature macro: RISCV_ADDER_ARB_WORD_EN (adds i_req_word, ADDW/SUBW).
module riscv_core_adder_arbiter #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREQ = 3,
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*XLEN-1:0] i_req_srcA,
    input  logic [NREQ*XLEN-1:0] i_req_srcB,
    input  logic [NREQ-1:0]      i_req_sub,
`ifdef RISCV_ADDER_ARB_WORD_EN
    input  logic [NREQ-1:0]      i_req_word,
`endif
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [ID_W-1:0]      o_rsp_id,
    output logic [XLEN-1:0]      o_rsp_result,
    output logic                 o_rsp_carry
);

    // Round-robin pointer: the first requester searched on the next grant.
    logic [ID_W-1:0] rr_ptr;

    logic            slot_free;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   idx_sum;
    logic [ID_W-1:0] cand;
    logic            xfer;
    logic [ID_W-1:0] rr_next;

    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic            sel_sub;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum_full;
    logic [XLEN-1:0] res_next;
    logic            carry_next;
`ifdef RISCV_ADDER_ARB_WORD_EN
    logic            sel_word;
    logic [32:0]     sum_lo;
`endif

    // The slot can take a new result when it is empty or is being drained now.
    assign slot_free = !o_rsp_valid || i_rsp_ready;

    // Rotating-priority search for the first valid requester, starting at rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_sum   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (idx_sum >= (ID_W+1)'(NREQ)) begin
                idx_sum = idx_sum - (ID_W+1)'(NREQ);
            end
            cand = ID_W'(idx_sum);
            if (!gnt_found && i_req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // One-hot grant, suppressed during reset or while the slot is blocked.
    always_comb begin
        o_req_ready = '0;
        if (gnt_found && slot_free && !i_rst) begin
            o_req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer    = |o_req_ready;
    assign rr_next = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    // Select the granted requester's operands for the shared adder.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
`ifdef RISCV_ADDER_ARB_WORD_EN
        sel_word = 1'b0;
`endif
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                sel_a   = i_req_srcA[k*XLEN +: XLEN];
                sel_b   = i_req_srcB[k*XLEN +: XLEN];
                sel_sub = i_req_sub[k];
`ifdef RISCV_ADDER_ARB_WORD_EN
                sel_word = i_req_word[k];
`endif
            end
        end
    end

    // Shared adder: A + (sub ? ~B : B) + sub, with carry-out in bit XLEN.
    always_comb begin
        b_eff    = sel_sub ? ~sel_b : sel_b;
        sum_full = {1'b0, sel_a} + {1'b0, b_eff} + (XLEN+1)'(sel_sub);
`ifdef RISCV_ADDER_ARB_WORD_EN
        // Word ops sign-extend the low 32 bits and carry out of bit 31.
        sum_lo = {1'b0, sel_a[31:0]} + {1'b0, b_eff[31:0]} + 33'(sel_sub);
        if (sel_word) begin
            res_next   = {{(XLEN-32){sum_lo[31]}}, sum_lo[31:0]};
            carry_next = sum_lo[32];
        end else begin
            res_next   = sum_full[XLEN-1:0];
            carry_next = sum_full[XLEN];
        end
`else
        res_next   = sum_full[XLEN-1:0];
        carry_next = sum_full[XLEN];
`endif
    end

    // Response slot and round-robin pointer; data fields hold when not loaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= '0;
            o_rsp_result <= '0;
            o_rsp_carry  <= 1'b0;
            rr_ptr       <= '0;
        end else if (xfer) begin
            o_rsp_valid  <= 1'b1;
            o_rsp_id     <= gnt_idx;
            o_rsp_result <= res_next;
            o_rsp_carry  <= carry_next;
            rr_ptr       <= rr_next;
        end else if (i_rsp_ready) begin
            o_rsp_valid  <= 1'b0;
        end
    end

endmodule
